// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scanner for a 4x4 active-low matrix keypad. One row at a time is driven low,
// the columns are sampled once per scan tick, and a press is accepted only
// after a run of consistent samples. Each accepted press produces one key code
// on a valid/ready interface. key_code uses the same 5-bit code the 7-segment
// display consumes, so a key can be shown directly.
//
// Parameters
//   SCAN_DIV        clock cycles per scan tick (>= 4)
//   DEBOUNCE_SCANS  consecutive equal tick samples that confirm press/release (>= 1)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   col_in     in   [3:0] keypad columns, pulled up, asynchronous to clk
//   row_out    out  [3:0] row drive, exactly one bit low, registered
//   key_code   out  [4:0] {1'b0, row, col} of the last accepted key
//   key_valid  out  a key code is pending
//   key_ready  in   consumer accepts when key_valid & key_ready
//   key_held   out  a confirmed key is still down
//   overrun    out  one-cycle pulse when a pending code was overwritten
// -----------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } cand_t;

  // ---------------------------------------------------------------------------
  // Column synchronizer. Flops reset to all-ones so nothing looks pressed.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] col_s;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
    end
  end

  assign col_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Scan tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Lowest-index low column; higher low columns are ignored.
  // ---------------------------------------------------------------------------
  logic       any_low;
  logic [1:0] low_col;

  always_comb begin
    any_low = ~&col_s;
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) low_col = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  cand_t            cand_q, cand_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]       row_out_q;
  logic             emit;
  cand_t            emit_code;
  logic             cand_col_low;

  assign cand_col_low = ~col_s[cand_q.col];

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    emit      = 1'b0;
    emit_code = cand_q;

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            // Freeze the row on the driven key; the row index stays put.
            cand_d    = '{row: row_q, col: low_col};
            deb_cnt_d = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              state_d   = ST_PRESSED;
              rel_cnt_d = '0;
              emit      = 1'b1;
              emit_code = '{row: row_q, col: low_col};
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (cand_col_low) begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
            if (deb_cnt_q + CNT_ONE == CNT_MAX) begin
              state_d   = ST_PRESSED;
              rel_cnt_d = '0;
              emit      = 1'b1;
            end
          end else begin
            // Bounce: give up and resume scanning from the next row.
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end

        ST_PRESSED: begin
          if (!cand_col_low) begin
            rel_cnt_d = rel_cnt_q + CNT_ONE;
            if (rel_cnt_q + CNT_ONE == CNT_MAX) begin
              state_d   = ST_SCAN;
              rel_cnt_d = '0;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end

        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      row_q     <= 2'd0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
      rel_cnt_q <= '0;
      row_out_q <= 4'b1110;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      row_out_q <= ~(4'b0001 << row_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake. An emit always wins over a transfer in the same cycle,
  // so a new code is never dropped; overrun flags a pending code being lost.
  // ---------------------------------------------------------------------------
  logic [4:0] key_code_q;
  logic       key_valid_q;
  logic       overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q  <= 5'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (emit) begin
        key_code_q  <= {1'b0, emit_code};
        key_valid_q <= 1'b1;
        overrun_q   <= key_valid_q & ~key_ready;
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_PRESSED);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3. A keypad
// model pulls a column low only while the key's row is driven. Outputs are
// sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overrun;

  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;
  int ov_cnt   = 0;
  int xfer_cnt = 0;
  int lat;

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Keypad model: key k sits at row k/4, column k%4.
  always_comb begin
    col_in = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !row_out[k / 4]) col_in[k % 4] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (key_valid && key_ready) xfer_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    for (int i = 0; i < budget && key_held !== val; i++) @(negedge clk);
    check(tag, 32'(key_held), 32'(val));
  endtask

  task automatic wait_valid(input int budget, input string tag, output int n);
    n = 0;
    while (n < budget && key_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_valid), 32'd1);
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    // ---------------- Reset mid-press ----------------
    cycles(2);
    rst = 1'b0;
    keys = 16'h0200;                       // key 9
    wait_held(1'b1, 100, "rst_setup_held");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_row_out",   32'(row_out),   32'hE);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_held",  32'(key_held),  32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    keys = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    check("step0", 32'(row_out), 32'hE);
    cycles(1);
    check("step1", 32'(row_out), 32'hD);
    cycles(4);
    check("step2", 32'(row_out), 32'hB);
    cycles(4);
    check("step3", 32'(row_out), 32'h7);
    cycles(4);
    check("step4", 32'(row_out), 32'hE);
    check("idle_valid", 32'(key_valid), 32'd0);

    // ---------------- Single press, key 9 ----------------
    keys = 16'h0200;
    wait_valid(100, "single_valid", lat);
    check("single_latency_ok", 32'(lat <= 30), 32'd1);
    check("single_code", 32'(key_code), 32'd9);
    check("single_held", 32'(key_held), 32'd1);
    cycles(40);
    check("single_valid_hold", 32'(key_valid), 32'd1);
    pulse_ready();
    check("single_valid_clr", 32'(key_valid), 32'd0);
    check("single_code_keep", 32'(key_code), 32'd9);
    keys = 16'h0000;
    wait_held(1'b0, 100, "single_release");
    check("single_one_emit", 32'(key_valid), 32'd0);

    // ---------------- Bounce, key 4 low for one tick ----------------
    for (int i = 0; i < 40 && row_out === 4'hD; i++) @(negedge clk);
    for (int i = 0; i < 40 && row_out !== 4'hD; i++) @(negedge clk);
    keys = 16'h0010;
    cycles(4);
    check("bounce_frozen", 32'(row_out), 32'hD);
    keys = 16'h0000;
    cycles(4);
    check("bounce_resume", 32'(row_out), 32'hB);
    cycles(40);
    check("bounce_no_valid", 32'(key_valid), 32'd0);

    // ---------------- Two keys in row 1: cols 0 and 3 ----------------
    keys = 16'h0090;                       // keys 4 and 7
    wait_valid(100, "two_valid", lat);
    check("two_code", 32'(key_code), 32'd4);
    pulse_ready();
    keys = 16'h0000;
    wait_held(1'b0, 100, "two_release");
    check("two_no_reemit", 32'(key_valid), 32'd0);

    // ---------------- Release/repress overrun, never ready ----------------
    ov_cnt = 0;
    keys = 16'h0020;                       // key 5
    wait_valid(100, "ovr_valid5", lat);
    check("ovr_code5", 32'(key_code), 32'd5);
    keys = 16'h0000;
    wait_held(1'b0, 100, "ovr_release5");
    keys = 16'h8000;                       // key 15
    wait_held(1'b1, 100, "ovr_held15");
    cycles(20);
    check("ovr_code15", 32'(key_code), 32'd15);
    check("ovr_valid15", 32'(key_valid), 32'd1);
    check("ovr_one_pulse", 32'(ov_cnt), 32'd1);
    pulse_ready();
    keys = 16'h0000;
    wait_held(1'b0, 100, "ovr_release15");

    // ---------------- Same sequence with ready held high ----------------
    ov_cnt   = 0;
    xfer_cnt = 0;
    key_ready = 1'b1;
    keys = 16'h0020;
    wait_held(1'b1, 100, "rdy_held5");
    keys = 16'h0000;
    wait_held(1'b0, 100, "rdy_release5");
    keys = 16'h8000;
    wait_held(1'b1, 100, "rdy_held15");
    keys = 16'h0000;
    wait_held(1'b0, 100, "rdy_release15");
    cycles(4);
    check("rdy_xfers", 32'(xfer_cnt), 32'd2);
    check("rdy_no_overrun", 32'(ov_cnt), 32'd0);
    check("rdy_code", 32'(key_code), 32'd15);
    check("rdy_valid_low", 32'(key_valid), 32'd0);
    key_ready = 1'b0;

    // ---------------- Release glitch during PRESSED ----------------
    ov_cnt = 0;
    keys = 16'h0200;                       // key 9
    wait_held(1'b1, 100, "gl_held");       // just after emit edge P
    keys = 16'h0000;
    cycles(8);                             // ticks P+4, P+8 see high
    check("gl_held_2hi", 32'(key_held), 32'd1);
    keys = 16'h0200;
    cycles(4);                             // tick P+12 sees low
    check("gl_held_lo", 32'(key_held), 32'd1);
    keys = 16'h0000;
    cycles(11);                            // ticks P+16, P+20 high
    check("gl_held_before", 32'(key_held), 32'd1);
    cycles(1);                             // tick P+24: third high
    check("gl_held_fall", 32'(key_held), 32'd0);
    check("gl_code", 32'(key_code), 32'd9);
    check("gl_valid", 32'(key_valid), 32'd1);
    check("gl_single_emit", 32'(ov_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
